// File: rtl/midside_pkg.sv
// midside_pkg: shared mode/state types and lane helpers for the mid-side mode sequencer.
package midside_pkg;

  typedef enum logic [1:0] {
    MS_BYPASS = 2'd0,
    MS_ENCODE = 2'd1,
    MS_DECODE = 2'd2
  } ms_mode_e;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_FADE_OUT,
    ST_DRAIN,
    ST_SWITCH,
    ST_FADE_IN
  } seq_state_e;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } lanes_t;

  function automatic lanes_t split_lanes(input logic [31:0] d);
    return lanes_t'(d);
  endfunction

  // The register block has no encoding for 3; treat it as bypass.
  function automatic ms_mode_e coerce_mode(input logic [1:0] m);
    return (m == 2'd3) ? MS_BYPASS : ms_mode_e'(m);
  endfunction

endpackage

// File: rtl/midside_gain_lane.sv
// midside_gain_lane: one signed 16-bit lane scaled by k / 2^RAMP_LOG2 with floor rounding.
module midside_gain_lane #(
  parameter int RAMP_LOG2 = 6
) (
  input  logic signed [15:0]       i_x,
  input  logic        [RAMP_LOG2:0] i_k,
  output logic signed [15:0]       o_y
);

  logic signed [16+RAMP_LOG2:0] w_x;
  logic signed [16+RAMP_LOG2:0] w_k;
  logic signed [16+RAMP_LOG2:0] w_prod;

  assign w_x    = {{(RAMP_LOG2+1){i_x[15]}}, i_x};
  assign w_k    = {16'd0, i_k};
  assign w_prod = w_x * w_k;
  // k never exceeds 2^RAMP_LOG2, so the shifted product always fits 16 bits.
  assign o_y    = 16'(w_prod >>> RAMP_LOG2);

endmodule

// File: rtl/midside_mode_sequencer.sv
// midside_mode_sequencer: owns the mid-side core mode and makes every mode change
// click-free by fading out, draining the core, switching, then fading back in.
module midside_mode_sequencer
  import midside_pkg::*;
#(
  parameter int RAMP_LOG2 = 6,
  parameter int PIPE_LAT  = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [1:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  output logic [1:0]  mode_active,
  output logic        busy,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam int KW = RAMP_LOG2 + 1;
  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [KW-1:0] K_FULL   = KW'(1 << RAMP_LOG2);
  localparam logic [KW-1:0] K_TOP    = KW'((1 << RAMP_LOG2) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PIPE_LAT - 1);

  seq_state_e    r_state, w_state_nxt;
  ms_mode_e      r_mode, w_mode_nxt;
  ms_mode_e      r_pending, w_pending_nxt;
  logic [KW-1:0] r_k, w_k_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_tvalid;
  logic [31:0]   r_tdata;
  logic          r_tlast;

  lanes_t         w_in;
  ms_mode_e       w_req_mode;
  logic signed [15:0] w_l, w_r;
  logic           w_load;
  logic           w_accept;

  assign w_in       = split_lanes(s_axis_tdata);
  assign w_req_mode = coerce_mode(mode_req);
  assign w_load     = !r_tvalid || m_axis_tready;
  assign w_accept   = s_axis_tvalid && s_axis_tready;

  assign s_axis_tready  = w_load && !(r_state inside {ST_DRAIN, ST_SWITCH});
  assign mode_req_ready = r_state == ST_RUN;
  assign busy           = r_state != ST_RUN;
  assign mode_active    = r_mode;
  assign m_axis_tdata   = r_tdata;
  assign m_axis_tvalid  = r_tvalid;
  assign m_axis_tlast   = r_tlast;

  midside_gain_lane #(.RAMP_LOG2(RAMP_LOG2)) u_gain_l (
    .i_x (w_in.l),
    .i_k (r_k),
    .o_y (w_l)
  );

  midside_gain_lane #(.RAMP_LOG2(RAMP_LOG2)) u_gain_r (
    .i_x (w_in.r),
    .i_k (r_k),
    .o_y (w_r)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_pending_nxt = r_pending;
    w_k_nxt       = r_k;
    w_cnt_nxt     = r_cnt;
    unique case (r_state)
      ST_RUN: begin
        // A beat accepted alongside the request still uses full gain from r_k.
        if (mode_req_valid && w_req_mode != r_mode) begin
          w_pending_nxt = w_req_mode;
          w_k_nxt       = K_TOP;
          w_state_nxt   = ST_FADE_OUT;
        end
      end
      ST_FADE_OUT: begin
        if (w_accept) begin
          if (r_k == '0) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DRAIN;
          end else begin
            w_k_nxt = r_k - KW'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Core flush time only starts once our own output register is empty.
        if (!r_tvalid) begin
          if (r_cnt == CNT_LAST) w_state_nxt = ST_SWITCH;
          else w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_SWITCH: begin
        w_mode_nxt  = r_pending;
        w_k_nxt     = KW'(1);
        w_state_nxt = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (w_accept) begin
          if (r_k == K_TOP) begin
            w_k_nxt     = K_FULL;
            w_state_nxt = ST_RUN;
          end else begin
            w_k_nxt = r_k + KW'(1);
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_RUN;
      r_mode    <= MS_BYPASS;
      r_pending <= MS_BYPASS;
      r_k       <= K_FULL;
      r_cnt     <= '0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_tlast   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_pending <= w_pending_nxt;
      r_k       <= w_k_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_load) begin
        r_tvalid <= w_accept;
        if (w_accept) begin
          r_tdata <= {w_l, w_r};
          r_tlast <= s_axis_tlast;
        end
      end
    end
  end

endmodule

// File: tb/tb_midside_mode_sequencer.sv
// tb_midside_mode_sequencer: directed stimulus with a queued scoreboard checked by an output monitor.
module tb_midside_mode_sequencer;

  localparam int RAMP_LOG2 = 2;
  localparam int PIPE_LAT  = 2;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  mode_req;
  logic        mode_req_valid;
  logic        mode_req_ready;
  logic [1:0]  mode_active;
  logic        busy;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;

  int checks = 0;
  int passes = 0;
  int n_push = 0;
  int n_pop  = 0;
  logic tog = 1'b0;
  logic [32:0] sb[$];

  logic signed [15:0] fo_l [4] = '{16'sd750, 16'sd500, 16'sd250, 16'sd0};
  logic signed [15:0] fi_l [3] = '{16'sd250, 16'sd500, 16'sd750};
  logic signed [15:0] ff_l [4] = '{-16'sd751, -16'sd501, -16'sd251, 16'sd0};
  logic signed [15:0] ff_r [4] = '{16'sd750, 16'sd500, 16'sd250, 16'sd0};
  logic signed [15:0] gi_l [3] = '{-16'sd251, -16'sd501, -16'sd751};
  logic signed [15:0] gi_r [3] = '{16'sd250, 16'sd500, 16'sd750};

  midside_mode_sequencer #(.RAMP_LOG2(RAMP_LOG2), .PIPE_LAT(PIPE_LAT)) dut (
    .aclk           (clk),
    .aresetn        (aresetn),
    .mode_req       (mode_req),
    .mode_req_valid (mode_req_valid),
    .mode_req_ready (mode_req_ready),
    .mode_active    (mode_active),
    .busy           (busy),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast)
  );

  always #5 clk = ~clk;

  always @(negedge clk) m_axis_tready = tog ? ~m_axis_tready : 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Output beats are consumed on the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    #2;
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL beat: unexpected output %0h", {m_axis_tlast, m_axis_tdata});
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        n_pop++;
        if ({m_axis_tlast, m_axis_tdata} !== e)
          $display("FAIL beat%0d: got %0h expected %0h", n_pop, {m_axis_tlast, m_axis_tdata}, e);
        else passes++;
      end
    end
  end

  task automatic send(input logic signed [15:0] l, input logic signed [15:0] r,
                      input logic signed [15:0] el, input logic signed [15:0] er,
                      input logic last, output int stall);
    stall = 0;
    @(negedge clk);
    s_axis_tdata  = {l, r};
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    #1;
    while (!s_axis_tready && stall < 100) begin
      @(negedge clk);
      #1;
      stall++;
    end
    if (stall >= 100) begin
      checks++;
      $display("FAIL send_timeout: tready stuck low for %0d cycles, required accept", stall);
      s_axis_tvalid = 1'b0;
    end else begin
      sb.push_back({last, el, er});
      n_push++;
    end
  endtask

  task automatic req(input logic [1:0] m);
    int n = 0;
    @(negedge clk);
    s_axis_tvalid  = 1'b0;
    mode_req       = m;
    mode_req_valid = 1'b1;
    #1;
    while (!mode_req_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      $display("FAIL req_timeout: ready stuck low, required high");
    end
    @(negedge clk);
    mode_req_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'd0);
    chk({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
    chk({tag, "_mode"}, 64'(mode_active), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_reqrdy"}, 64'(mode_req_ready), 64'd1);
  endtask

  initial begin
    int st;
    int n;
    logic signed [15:0] a, b;
    aresetn = 1'b0;
    mode_req = 2'd0;
    mode_req_valid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    aresetn = 1'b1;

    for (int i = 0; i < 4; i++) send(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000, i == 3, st);
    idle();
    #1;
    chk("run_mode", 64'(mode_active), 64'd0);
    chk("run_busy", 64'(busy), 64'd0);

    req(2'd1);
    #1;
    chk("seq_busy", 64'(busy), 64'd1);
    chk("seq_reqrdy", 64'(mode_req_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      send(16'sd1000, -16'sd1000, fo_l[i], -fo_l[i], i == 3, st);
      chk("fo_mode", 64'(mode_active), 64'd0);
      chk("fo_reqrdy", 64'(mode_req_ready), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      send(16'sd1000, -16'sd1000, fi_l[i], -fi_l[i], 1'b0, st);
      if (i == 0) begin
        chk("drain_stall", 64'(st >= PIPE_LAT), 64'd1);
        chk("fi_mode", 64'(mode_active), 64'd1);
      end
      chk("fi_reqrdy", 64'(mode_req_ready), 64'd0);
    end
    send(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000, 1'b1, st);
    chk("back_busy", 64'(busy), 64'd0);
    idle();

    req(2'd1);
    #1;
    chk("same_busy", 64'(busy), 64'd0);
    chk("same_mode", 64'(mode_active), 64'd1);

    a = -16'sd1001;
    b = 16'sd1001;
    @(negedge clk);
    mode_req = 2'd2;
    mode_req_valid = 1'b1;
    s_axis_tdata = {a, b};
    s_axis_tvalid = 1'b1;
    s_axis_tlast = 1'b0;
    #1;
    chk("both_ready", 64'(s_axis_tready && mode_req_ready), 64'd1);
    sb.push_back({1'b0, a, b});
    n_push++;
    @(negedge clk);
    mode_req_valid = 1'b0;
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < 4; i++) send(a, b, ff_l[i], ff_r[i], 1'b0, st);
    for (int i = 0; i < 3; i++) send(a, b, gi_l[i], gi_r[i], i == 2, st);
    send(a, b, a, b, 1'b0, st);
    chk("floor_mode", 64'(mode_active), 64'd2);
    idle();

    tog = 1'b1;
    req(2'd0);
    for (int i = 0; i < 4; i++) send(16'sd1000, -16'sd1000, fo_l[i], -fo_l[i], i == 3, st);
    for (int i = 0; i < 3; i++) send(16'sd1000, -16'sd1000, fi_l[i], -fi_l[i], 1'b0, st);
    for (int i = 0; i < 2; i++) send(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000, i == 1, st);
    chk("tog_mode", 64'(mode_active), 64'd0);
    idle();
    tog = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("tog_count", 64'(n_pop), 64'(n_push));

    req(2'd3);
    #1;
    chk("m3_busy", 64'(busy), 64'd0);
    chk("m3_mode", 64'(mode_active), 64'd0);

    req(2'd1);
    for (int i = 0; i < 4; i++) send(16'sd1000, -16'sd1000, fo_l[i], -fo_l[i], 1'b0, st);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1;
    chk("drain_busy", 64'(busy), 64'd1);
    aresetn = 1'b0;
    #1;
    chk_reset("mid");
    if (sb.size() != 0) begin
      sb.delete();
      n_push--;
    end
    @(negedge clk);
    aresetn = 1'b1;
    for (int i = 0; i < 2; i++) send(16'sd1000, -16'sd1000, 16'sd1000, -16'sd1000, 1'b0, st);
    chk("post_mode", 64'(mode_active), 64'd0);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("beat_count", 64'(n_pop), 64'(n_push));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
